// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared state encoding, forwarding selects and wait limit
package pipe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [7:0] WAIT_LIMIT = 8'd255;
  // nearer producer wins; register 0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic p1_wr,
                                         input logic [4:0] p1_rd, input logic p2_wr,
                                         input logic [4:0] p2_rd);
    return (p1_wr && p1_rd != 5'd0 && p1_rd == src) ? FWD_EXMEM :
           (p2_wr && p2_rd != 5'd0 && p2_rd == src) ? FWD_MEMWB : FWD_RF;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-to-hazard-controller signal bundle
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs_i, id_rt_i;
  logic        id_uses_rt_i;
  logic [4:0]  ex_rs_i, ex_rt_i, ex_rd_i;
  logic        ex_memtoreg_i, ex_regwr_i;
  logic        mem_regwr_i, wb_regwr_i;
  logic [4:0]  mem_rd_i, wb_rd_i;
  logic        branch_taken_i, mem_wait_i;
  logic        pc_wr_en_o, if_id_wr_en_o, if_id_flush_o, id_ex_bubble_o;
  logic        id_ex_hold_o, ex_mem_hold_o, mem_wb_hold_o;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic [15:0] stall_cycles_o;
  logic        mem_timeout_o;
  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_rs_i, ex_rt_i, ex_rd_i, ex_memtoreg_i,
           ex_regwr_i, mem_regwr_i, wb_regwr_i, mem_rd_i, wb_rd_i, branch_taken_i, mem_wait_i,
    input  pc_wr_en_o, if_id_wr_en_o, if_id_flush_o, id_ex_bubble_o, id_ex_hold_o,
           ex_mem_hold_o, mem_wb_hold_o, fwd_a_o, fwd_b_o, stall_cycles_o, mem_timeout_o
  );
  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_rs_i, ex_rt_i, ex_rd_i, ex_memtoreg_i,
           ex_regwr_i, mem_regwr_i, wb_regwr_i, mem_rd_i, wb_rd_i, branch_taken_i, mem_wait_i,
    output pc_wr_en_o, if_id_wr_en_o, if_id_flush_o, id_ex_bubble_o, id_ex_hold_o,
           ex_mem_hold_o, mem_wb_hold_o, fwd_a_o, fwd_b_o, stall_cycles_o, mem_timeout_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// haz_fwd_unit: compares two source registers against two producer stages
module haz_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_a_i,
  input  logic [4:0] src_b_i,
  input  logic       use_b_i,
  input  logic       p1_wr_i,
  input  logic [4:0] p1_rd_i,
  input  logic       p2_wr_i,
  input  logic [4:0] p2_rd_i,
  output logic [1:0] sel_a_o,
  output logic [1:0] sel_b_o
);
  assign sel_a_o = fwd_sel(src_a_i, p1_wr_i, p1_rd_i, p2_wr_i, p2_rd_i);
  assign sel_b_o = use_b_i ? fwd_sel(src_b_i, p1_wr_i, p1_rd_i, p2_wr_i, p2_rd_i) : FWD_RF;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush FSM, forwarding and stall statistics; HAZ_FWD_EN enables forwarding
// Without HAZ_FWD_EN every RAW on an EX/MEM producer stalls instead of forwarding.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  state_e      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic [7:0]  wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  sel_a, sel_b;
  logic        hazard;
`ifdef HAZ_FWD_EN
  haz_fwd_unit u_fwd (
    .src_a_i(bus.ex_rs_i), .src_b_i(bus.ex_rt_i), .use_b_i(1'b1),
    .p1_wr_i(bus.mem_regwr_i), .p1_rd_i(bus.mem_rd_i),
    .p2_wr_i(bus.wb_regwr_i), .p2_rd_i(bus.wb_rd_i),
    .sel_a_o(sel_a), .sel_b_o(sel_b)
  );
  // a load-use is only raised from RUN: after a stall or flush the ID/EX slot is a bubble
  assign hazard = state_q == RUN && bus.ex_memtoreg_i && bus.ex_regwr_i && bus.ex_rd_i != 5'd0 &&
                  (bus.ex_rd_i == bus.id_rs_i || (bus.id_uses_rt_i && bus.ex_rd_i == bus.id_rt_i));
  assign bus.fwd_a_o = sel_a;
  assign bus.fwd_b_o = sel_b;
`else
  haz_fwd_unit u_fwd (
    .src_a_i(bus.id_rs_i), .src_b_i(bus.id_rt_i), .use_b_i(bus.id_uses_rt_i),
    .p1_wr_i(bus.ex_regwr_i), .p1_rd_i(bus.ex_rd_i),
    .p2_wr_i(bus.mem_regwr_i), .p2_rd_i(bus.mem_rd_i),
    .sel_a_o(sel_a), .sel_b_o(sel_b)
  );
  logic unused_ok;
  assign unused_ok = ^{bus.ex_rs_i, bus.ex_rt_i, bus.ex_memtoreg_i, bus.wb_regwr_i, bus.wb_rd_i};
  assign hazard = state_q != FLUSH && (sel_a != FWD_RF || sel_b != FWD_RF);
  assign bus.fwd_a_o = FWD_RF;
  assign bus.fwd_b_o = FWD_RF;
`endif
  always_comb begin
    state_d   = bus.mem_wait_i ? MEM_WAIT : state_q == MEM_WAIT ? RUN :
                bus.branch_taken_i ? FLUSH : hazard ? LU_STALL : RUN;
    stall_d   = (state_q != RUN && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    wait_d    = state_d != MEM_WAIT ? 8'd0 : wait_q == WAIT_LIMIT ? wait_q : wait_q + 8'd1;
    timeout_d = timeout_q | (state_q == MEM_WAIT && bus.mem_wait_i && wait_q == WAIT_LIMIT);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      stall_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.pc_wr_en_o     = state_q == RUN || state_q == FLUSH;
  assign bus.if_id_wr_en_o  = state_q == RUN || state_q == FLUSH;
  assign bus.if_id_flush_o  = state_q == FLUSH;
  assign bus.id_ex_bubble_o = state_q == LU_STALL || state_q == FLUSH;
  assign bus.id_ex_hold_o   = state_q == MEM_WAIT;
  assign bus.ex_mem_hold_o  = state_q == MEM_WAIT;
  assign bus.mem_wb_hold_o  = state_q == MEM_WAIT;
  assign bus.stall_cycles_o = stall_q;
  assign bus.mem_timeout_o  = timeout_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks against a behavioural model
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] ctl;
  assign ctl = {bus.pc_wr_en_o, bus.if_id_wr_en_o, bus.if_id_flush_o, bus.id_ex_bubble_o,
                bus.id_ex_hold_o, bus.ex_mem_hold_o, bus.mem_wb_hold_o};
  localparam logic [6:0] C_RUN = 7'b1100000, C_LU = 7'b0001000, C_FL = 7'b1111000, C_MW = 7'b0000111;
  // model: 0 run, 1 load-use stall, 2 flush, 3 memory wait
  int m_mode = 0, m_stalls = 0, m_run = 0;
  bit m_to = 0;
  function automatic logic [6:0] ctl_for(input int mode);
    return mode == 1 ? C_LU : mode == 2 ? C_FL : mode == 3 ? C_MW : C_RUN;
  endfunction
  function automatic bit reads(input logic wr, input logic [4:0] rd);
    return wr && rd != 0 && (rd == bus.id_rs_i || (bus.id_uses_rt_i && rd == bus.id_rt_i));
  endfunction
  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
`ifdef HAZ_FWD_EN
    if (bus.mem_regwr_i && bus.mem_rd_i != 0 && bus.mem_rd_i == src) return 2'b10;
    if (bus.wb_regwr_i && bus.wb_rd_i != 0 && bus.wb_rd_i == src) return 2'b01;
`endif
    return 2'b00;
  endfunction
  task automatic tick();
    bit hz;
    if (!rst) begin
      m_mode = 0; m_stalls = 0; m_run = 0; m_to = 0;
    end else begin
      if (m_mode != 0 && m_stalls < 65535) m_stalls++;
      m_run = bus.mem_wait_i ? m_run + 1 : 0;
      if (m_run >= 256) m_to = 1;
`ifdef HAZ_FWD_EN
      hz = m_mode == 0 && bus.ex_memtoreg_i && reads(bus.ex_regwr_i, bus.ex_rd_i);
`else
      hz = m_mode != 2 && (reads(bus.ex_regwr_i, bus.ex_rd_i) || reads(bus.mem_regwr_i, bus.mem_rd_i));
`endif
      m_mode = bus.mem_wait_i ? 3 : m_mode == 3 ? 0 : bus.branch_taken_i ? 2 : hz ? 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    rst = 1'b1;
    {bus.id_rs_i, bus.id_rt_i, bus.id_uses_rt_i, bus.ex_rs_i, bus.ex_rt_i, bus.ex_rd_i} = '0;
    {bus.ex_memtoreg_i, bus.ex_regwr_i, bus.mem_regwr_i, bus.mem_rd_i} = '0;
    {bus.wb_regwr_i, bus.wb_rd_i, bus.branch_taken_i, bus.mem_wait_i} = '0;
    tick();
  endtask
  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    checks += 3;
    if (ctl !== C_RUN) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_RUN); end
    if (bus.stall_cycles_o !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", bus.stall_cycles_o); end
    if (bus.mem_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.mem_timeout_o); end
    rst = 1'b1;
  endtask
  task automatic test_forward();
    logic [1:0] ea, eb;
    clear_inputs();
    bus.mem_regwr_i = 1; bus.mem_rd_i = 5; bus.wb_regwr_i = 1; bus.wb_rd_i = 5;
    bus.ex_rs_i = 5; bus.ex_rt_i = 5;
    #1;
`ifdef HAZ_FWD_EN
    ea = 2'b10; eb = 2'b10;
`else
    ea = 2'b00; eb = 2'b00;
`endif
    checks += 2;
    if (bus.fwd_a_o !== ea) begin errors++; $display("FAIL fwd_double_a: got %b expected %b", bus.fwd_a_o, ea); end
    if (bus.fwd_b_o !== eb) begin errors++; $display("FAIL fwd_double_b: got %b expected %b", bus.fwd_b_o, eb); end
    bus.mem_rd_i = 0;
    #1;
`ifdef HAZ_FWD_EN
    ea = 2'b01;
`endif
    checks++;
    if (bus.fwd_a_o !== ea) begin errors++; $display("FAIL fwd_wb_only: got %b expected %b", bus.fwd_a_o, ea); end
    bus.ex_rs_i = 0; bus.wb_rd_i = 0; bus.mem_rd_i = 0;
    #1;
    checks++;
    if (bus.fwd_a_o !== 2'b00) begin errors++; $display("FAIL fwd_zero: got %b expected 00", bus.fwd_a_o); end
  endtask
  task automatic test_load_use();
    clear_inputs();
    bus.ex_memtoreg_i = 1; bus.ex_regwr_i = 1; bus.ex_rd_i = 2;
    bus.id_rs_i = 2; bus.id_rt_i = 4; bus.id_uses_rt_i = 1;
    tick();
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL lu_stall: got %b expected %b", ctl, C_LU); end
    bus.ex_memtoreg_i = 0; bus.ex_regwr_i = 0; bus.ex_rd_i = 0;
    bus.mem_regwr_i = 1; bus.mem_rd_i = 2;
    tick();
`ifndef HAZ_FWD_EN
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL lu_stall_mem: got %b expected %b", ctl, C_LU); end
    bus.mem_regwr_i = 0; bus.mem_rd_i = 0; bus.wb_regwr_i = 1; bus.wb_rd_i = 2;
    tick();
`endif
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL lu_resume: got %b expected %b", ctl, C_RUN); end
    bus.id_rs_i = 0; bus.id_rt_i = 0;
    bus.ex_rs_i = 2; bus.ex_rt_i = 4; bus.ex_regwr_i = 1; bus.ex_rd_i = 3;
    bus.mem_regwr_i = 0; bus.mem_rd_i = 0; bus.wb_regwr_i = 1; bus.wb_rd_i = 2;
    #1;
    checks += 2;
`ifdef HAZ_FWD_EN
    if (bus.fwd_a_o !== 2'b01) begin errors++; $display("FAIL lu_fwd_a: got %b expected 01", bus.fwd_a_o); end
`else
    if (bus.fwd_a_o !== 2'b00) begin errors++; $display("FAIL lu_fwd_a: got %b expected 00", bus.fwd_a_o); end
`endif
    if (bus.fwd_b_o !== 2'b00) begin errors++; $display("FAIL lu_fwd_b: got %b expected 00", bus.fwd_b_o); end
  endtask
  task automatic test_raw_alu();
    logic [6:0] e1, e2;
    clear_inputs();
    bus.ex_regwr_i = 1; bus.ex_rd_i = 3; bus.id_rs_i = 3; bus.id_rt_i = 5; bus.id_uses_rt_i = 1;
`ifdef HAZ_FWD_EN
    e1 = C_RUN; e2 = C_RUN;
`else
    e1 = C_LU; e2 = C_LU;
`endif
    tick();
    checks++;
    if (ctl !== e1) begin errors++; $display("FAIL raw_cycle1: got %b expected %b", ctl, e1); end
    bus.ex_regwr_i = 0; bus.ex_rd_i = 0; bus.mem_regwr_i = 1; bus.mem_rd_i = 3;
    tick();
    checks++;
    if (ctl !== e2) begin errors++; $display("FAIL raw_cycle2: got %b expected %b", ctl, e2); end
    bus.mem_regwr_i = 0; bus.mem_rd_i = 0; bus.wb_regwr_i = 1; bus.wb_rd_i = 3;
    tick();
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL raw_clear: got %b expected %b", ctl, C_RUN); end
  endtask
  task automatic test_branch();
    clear_inputs();
    bus.ex_memtoreg_i = 1; bus.ex_regwr_i = 1; bus.ex_rd_i = 7; bus.id_rs_i = 7;
    bus.branch_taken_i = 1;
    tick();
    checks++;
    if (ctl !== C_FL) begin errors++; $display("FAIL br_flush: got %b expected %b", ctl, C_FL); end
    bus.branch_taken_i = 0;
    tick();
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL br_discard_lu: got %b expected %b", ctl, C_RUN); end
    clear_inputs();
    bus.branch_taken_i = 1; bus.mem_wait_i = 1;
    tick();
    checks++;
    if (ctl !== C_MW) begin errors++; $display("FAIL br_memwait_prio: got %b expected %b", ctl, C_MW); end
    bus.mem_wait_i = 0;
    tick();
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL br_wait_exit: got %b expected %b", ctl, C_RUN); end
  endtask
  task automatic test_mem_timeout();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.mem_wait_i = 1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      checks += 2;
      if (ctl !== C_MW) begin errors++; $display("FAIL to_hold[%0d]: got %b expected %b", k, ctl, C_MW); end
      if (bus.mem_timeout_o !== (k >= 256)) begin
        errors++; $display("FAIL to_flag[%0d]: got %b expected %b", k, bus.mem_timeout_o, k >= 256);
      end
    end
    bus.mem_wait_i = 0;
    tick();
    checks += 3;
    if (ctl !== C_RUN) begin errors++; $display("FAIL to_exit: got %b expected %b", ctl, C_RUN); end
    if (bus.stall_cycles_o !== 16'd300) begin errors++; $display("FAIL to_stalls: got %0d expected 300", bus.stall_cycles_o); end
    if (bus.mem_timeout_o !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", bus.mem_timeout_o); end
  endtask
  task automatic test_reset_mid_wait();
    bus.mem_wait_i = 1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks += 3;
    if (ctl !== C_RUN) begin errors++; $display("FAIL rmw_ctl: got %b expected %b", ctl, C_RUN); end
    if (bus.stall_cycles_o !== 16'd0) begin errors++; $display("FAIL rmw_stalls: got %0d expected 0", bus.stall_cycles_o); end
    if (bus.mem_timeout_o !== 1'b0) begin errors++; $display("FAIL rmw_timeout: got %b expected 0", bus.mem_timeout_o); end
    rst = 1'b1;
    bus.mem_wait_i = 0;
  endtask
  task automatic test_random();
    logic [1:0] ea, eb;
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(63) != 0;
      bus.mem_wait_i = $urandom_range(7) == 0;
      bus.branch_taken_i = $urandom_range(7) == 0;
      bus.id_rs_i = 5'($urandom_range(3)); bus.id_rt_i = 5'($urandom_range(3));
      bus.ex_rs_i = 5'($urandom_range(3)); bus.ex_rt_i = 5'($urandom_range(3));
      bus.ex_rd_i = 5'($urandom_range(3)); bus.mem_rd_i = 5'($urandom_range(3));
      bus.wb_rd_i = 5'($urandom_range(3));
      bus.id_uses_rt_i = 1'($urandom); bus.ex_memtoreg_i = 1'($urandom);
      bus.ex_regwr_i = 1'($urandom); bus.mem_regwr_i = 1'($urandom); bus.wb_regwr_i = 1'($urandom);
      #1;
      ea = ref_fwd(bus.ex_rs_i);
      eb = ref_fwd(bus.ex_rt_i);
      checks += 2;
      if (bus.fwd_a_o !== ea) begin errors++; $display("FAIL rnd_fwd_a[%0d]: got %b expected %b", i, bus.fwd_a_o, ea); end
      if (bus.fwd_b_o !== eb) begin errors++; $display("FAIL rnd_fwd_b[%0d]: got %b expected %b", i, bus.fwd_b_o, eb); end
      tick();
      checks += 3;
      if (ctl !== ctl_for(m_mode)) begin errors++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", i, ctl, ctl_for(m_mode)); end
      if (bus.stall_cycles_o !== 16'(m_stalls)) begin
        errors++; $display("FAIL rnd_stalls[%0d]: got %0d expected %0d", i, bus.stall_cycles_o, m_stalls);
      end
      if (bus.mem_timeout_o !== m_to) begin errors++; $display("FAIL rnd_timeout[%0d]: got %b expected %b", i, bus.mem_timeout_o, m_to); end
    end
  endtask
  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_raw_alu();
    test_branch();
    test_mem_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
